// File: rtl/dualport_ram_bist.sv
// BIST initiator for the dual-port RAM: three march write/read pairs with a
// one-stage read compare pipeline and first-failure capture.
module dualport_ram_bist #(
  parameter int                   RAM_WIDTH = 8,
  parameter int                   RAM_DEPTH = 16,
  parameter int                   ADDR_SIZE = 4,
  parameter logic [RAM_WIDTH-1:0] PATTERN   = 8'h55
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 write,
  output logic                 read,
  output logic [ADDR_SIZE-1:0] wr_addr,
  output logic [ADDR_SIZE-1:0] rd_addr,
  output logic [RAM_WIDTH-1:0] data_in,
  input  logic [RAM_WIDTH-1:0] data_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ADDR_SIZE-1:0] fail_addr,
  output logic [RAM_WIDTH-1:0] fail_data
);

  // state | meaning
  // IDLE  | waiting for start, results held
  // W0/R0 | write/read PATTERN, ascending
  // W1/R1 | write/read ~PATTERN, descending
  // WA/RA | write/read address-as-data, ascending
  // FIN   | last RA compare, then done pulse
  typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, WA, RA, FIN} state_t;

  localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(RAM_DEPTH - 1);

  state_t               state, state_nxt;
  logic [ADDR_SIZE-1:0] cnt, cnt_nxt;

  logic                 write_nxt, read_nxt, busy_nxt, done_nxt, pass_nxt;
  logic [ADDR_SIZE-1:0] wr_addr_nxt, rd_addr_nxt, fail_addr_nxt;
  logic [RAM_WIDTH-1:0] data_in_nxt, fail_data_nxt;
  logic                 fail_flag, fail_flag_nxt;

  logic                 chk_valid;
  logic [ADDR_SIZE-1:0] chk_addr;
  logic [RAM_WIDTH-1:0] chk_exp, exp_cur;
  logic                 mismatch, capture;

  // Expected value of the read being issued this cycle; it travels with the read.
  always_comb begin
    exp_cur = RAM_WIDTH'(rd_addr);
    if (state == R0)      exp_cur = PATTERN;
    else if (state == R1) exp_cur = ~PATTERN;
  end

  assign mismatch = chk_valid && (data_out != chk_exp);
  assign capture  = mismatch && !fail_flag;

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    pass_nxt      = pass;
    fail_flag_nxt = fail_flag | mismatch;
    fail_addr_nxt = capture ? chk_addr : fail_addr;
    fail_data_nxt = capture ? data_out : fail_data;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt     = W0;
          cnt_nxt       = '0;
          busy_nxt      = 1'b1;
          pass_nxt      = 1'b0;
          fail_flag_nxt = 1'b0;
          fail_addr_nxt = '0;
          fail_data_nxt = '0;
        end
      end
      FIN: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        pass_nxt  = ~(fail_flag | mismatch);
      end
      default: begin
        if (cnt == LAST) begin
          state_nxt = state_t'(state + 3'd1);
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
    endcase
  end

  // RAM bus for the cycle we are entering, so every output is a plain register.
  always_comb begin
    write_nxt   = 1'b0;
    read_nxt    = 1'b0;
    wr_addr_nxt = '0;
    rd_addr_nxt = '0;
    data_in_nxt = '0;
    case (state_nxt)
      W0: begin
        write_nxt   = 1'b1;
        wr_addr_nxt = cnt_nxt;
        data_in_nxt = PATTERN;
      end
      R0: begin
        read_nxt    = 1'b1;
        rd_addr_nxt = cnt_nxt;
      end
      W1: begin
        write_nxt   = 1'b1;
        wr_addr_nxt = LAST - cnt_nxt;
        data_in_nxt = ~PATTERN;
      end
      R1: begin
        read_nxt    = 1'b1;
        rd_addr_nxt = LAST - cnt_nxt;
      end
      WA: begin
        write_nxt   = 1'b1;
        wr_addr_nxt = cnt_nxt;
        data_in_nxt = RAM_WIDTH'(cnt_nxt);
      end
      RA: begin
        read_nxt    = 1'b1;
        rd_addr_nxt = cnt_nxt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write     <= 1'b0;
      read      <= 1'b0;
      wr_addr   <= '0;
      rd_addr   <= '0;
      data_in   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      fail_flag <= 1'b0;
      chk_valid <= 1'b0;
      chk_addr  <= '0;
      chk_exp   <= '0;
    end else begin
      write     <= write_nxt;
      read      <= read_nxt;
      wr_addr   <= wr_addr_nxt;
      rd_addr   <= rd_addr_nxt;
      data_in   <= data_in_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      fail_addr <= fail_addr_nxt;
      fail_data <= fail_data_nxt;
      fail_flag <= fail_flag_nxt;
      chk_valid <= read;
      chk_addr  <= rd_addr;
      chk_exp   <= exp_cur;
    end
  end

endmodule

// File: tb/tb_dualport_ram_bist.sv
// Bench for dualport_ram_bist: RAM model with injectable faults, march
// reference model, directed and randomized fault runs.
module tb_dualport_ram_bist;
  localparam int W = 8;
  localparam int D = 16;
  localparam int A = 4;
  localparam int N = 3 * D;
  localparam logic [W-1:0] PAT = 8'h55;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         write, read, busy, done, pass;
  logic [A-1:0] wr_addr, rd_addr, fail_addr;
  logic [W-1:0] data_in, data_out, fail_data;

  int vectors = 0;
  int errors  = 0;

  // fault_kind: 0 none, 1 stuck-at bit on read, 2 writes to addr 3 land in addr 11
  int           fault_kind = 0;
  logic [A-1:0] sa_addr = '0;
  int           sa_bit = 0;
  logic         sa_val = 1'b0;

  logic [W-1:0] mem      [D];
  logic [W-1:0] init_img [D];
  logic         init_req = 1'b0;

  logic [A-1:0] exp_wa [N];
  logic [W-1:0] exp_wd [N];
  logic [A-1:0] exp_ra [N];
  logic         exp_pass;
  logic [A-1:0] exp_fa;
  logic [W-1:0] exp_fd;

  dualport_ram_bist dut (
    .clk(clk), .rst(rst), .start(start),
    .write(write), .read(read), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .data_in(data_in), .data_out(data_out),
    .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  function automatic logic [A-1:0] wr_target(logic [A-1:0] a);
    if (fault_kind == 2 && a == 4'd3) return 4'd11;
    return a;
  endfunction

  function automatic logic [W-1:0] rd_view(logic [A-1:0] a, logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    if (fault_kind == 1 && a == sa_addr) r[sa_bit] = sa_val;
    return r;
  endfunction

  function automatic logic [W-1:0] phase_data(int p, logic [A-1:0] a);
    if (p == 0) return PAT;
    if (p == 1) return ~PAT;
    return W'(a);
  endfunction

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < D; i++) mem[i] <= init_img[i];
      data_out <= '0;
    end else begin
      if (write) mem[wr_target(wr_addr)] <= data_in;
      if (read)  data_out <= rd_view(rd_addr, mem[rd_addr]);
    end
  end

  // March run as a list of operations over an array holding the faulty RAM.
  task automatic build_model();
    logic [W-1:0] m [D];
    logic [A-1:0] a;
    logic [W-1:0] obs;
    bit found;
    found = 0;
    exp_fa = '0;
    exp_fd = '0;
    for (int i = 0; i < D; i++) m[i] = init_img[i];
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < D; k++) begin
        a = (p == 1) ? A'(D - 1 - k) : A'(k);
        exp_wa[p*D+k] = a;
        exp_wd[p*D+k] = phase_data(p, a);
        m[wr_target(a)] = phase_data(p, a);
      end
      for (int k = 0; k < D; k++) begin
        a = (p == 1) ? A'(D - 1 - k) : A'(k);
        exp_ra[p*D+k] = a;
        obs = rd_view(a, m[a]);
        if (!found && obs != phase_data(p, a)) begin
          found = 1;
          exp_fa = a;
          exp_fd = obs;
        end
      end
    end
    exp_pass = !found;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_ram();
    for (int i = 0; i < D; i++) init_img[i] = W'($urandom);
  endtask

  // cyc n is the cycle after the n-th edge following the start edge; cycle 1
  // carries the first write, done is due in cycle 6*D+2.
  task automatic run(input int abort_cyc, input int restart_cyc);
    int wi, ri, done_cnt, done_cyc;
    wi = 0; ri = 0; done_cnt = 0; done_cyc = 0;
    build_model();
    @(negedge clk); init_req = 1'b1;
    @(negedge clk); init_req = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc <= 110; cyc++) begin
      if (cyc == abort_cyc) begin
        rst = 1'b0;
        #1;
        chk("abort_ctrl_zero", 32'({write, read, busy, done, pass}), 0);
        chk("abort_bus_zero", 32'({wr_addr, rd_addr, data_in}), 0);
        chk("abort_result_zero", 32'({fail_addr, fail_data}), 0);
        @(negedge clk); rst = 1'b1;
        return;
      end
      if (cyc == restart_cyc) start = 1'b1;
      else if (cyc == restart_cyc + 1) start = 1'b0;
      chk("rw_exclusive", 32'(write & read), 0);
      if (write) begin
        if (wi < N) begin
          chk("wr_addr", 32'(wr_addr), 32'(exp_wa[wi]));
          chk("wr_data", 32'(data_in), 32'(exp_wd[wi]));
        end
        wi++;
      end else begin
        chk("idle_wr_bus", 32'({wr_addr, data_in}), 0);
      end
      if (read) begin
        if (ri < N) chk("rd_addr", 32'(rd_addr), 32'(exp_ra[ri]));
        ri++;
      end else begin
        chk("idle_rd_addr", 32'(rd_addr), 0);
      end
      if (cyc == 1)  chk("first_write", 32'(write), 1);
      if (cyc == 33) chk("w1_first_addr", 32'(wr_addr), 15);
      if (cyc == 48) chk("w1_last_addr", 32'(wr_addr), 0);
      if (cyc == 75) chk("wa_data_at_10", 32'({write, wr_addr, data_in}), 32'({1'b1, 4'd10, 8'h0A}));
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      chk("busy", 32'(busy), 32'(done_cyc == 0));
      @(negedge clk);
    end
    chk("write_count", 32'(wi), N);
    chk("read_count", 32'(ri), N);
    chk("done_cycle", 32'(done_cyc), 6 * D + 2);
    chk("done_pulses", 32'(done_cnt), 1);
    chk("pass_model", 32'(pass), 32'(exp_pass));
    chk("fail_addr_model", 32'(fail_addr), 32'(exp_fa));
    chk("fail_data_model", 32'(fail_data), 32'(exp_fd));
  endtask

  initial begin
    #12;
    chk("reset_ctrl", 32'({write, read, busy, done, pass}), 0);
    chk("reset_bus", 32'({wr_addr, rd_addr, data_in, fail_addr, fail_data}), 0);
    @(negedge clk); rst = 1'b1;

    // clean RAM
    fault_kind = 0; randomize_ram();
    run(0, 0);
    chk("clean_pass", 32'(pass), 1);
    chk("clean_fail_addr", 32'(fail_addr), 0);
    chk("clean_fail_data", 32'(fail_data), 0);

    // bit0 stuck-at-0 at address 5
    fault_kind = 1; sa_addr = 4'd5; sa_bit = 0; sa_val = 1'b0; randomize_ram();
    run(0, 0);
    chk("sa0_pass", 32'(pass), 0);
    chk("sa0_fail_addr", 32'(fail_addr), 5);
    chk("sa0_fail_data", 32'(fail_data), 'h54);

    // decoder alias 3 -> 11
    fault_kind = 2; randomize_ram();
    if (init_img[3] == PAT) init_img[3] = 8'h00;
    run(0, 0);
    chk("alias_pass", 32'(pass), 0);
    chk("alias_fail_addr", 32'(fail_addr), 3);
    chk("alias_fail_data", 32'(fail_data), 32'(init_img[3]));

    // reset during R1, then a full clean run
    fault_kind = 0; randomize_ram();
    run(55, 0);
    chk("post_abort_pass", 32'(pass), 0);
    randomize_ram();
    run(0, 0);
    chk("restart_pass", 32'(pass), 1);

    // start pulsed during W1 is ignored
    randomize_ram();
    run(0, 40);
    chk("restart_ignored_pass", 32'(pass), 1);

    // random stuck-at faults
    for (int t = 0; t < 4; t++) begin
      fault_kind = 1;
      sa_addr = A'($urandom_range(0, D - 1));
      sa_bit  = int'($urandom_range(0, W - 1));
      sa_val  = 1'($urandom_range(0, 1));
      randomize_ram();
      run(0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
